device_status_reader: RTL and testbench
=======================================

// Module: device_status_reader
// PURPOSE
//  Read-back path of the home-appliance controller. The write side steers inp[4:0] into device registers.
//  This block selects one device status value with the same selector encoding (s0..s5).
//  It snapshots that value and sends it on a single-wire UART-style serial line.
//  Sits beside the top level; it is driven by the fridge/aircon/washer outputs.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit (legal 2..255)
//  W             5   status value width
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  async active-low reset
//  req        in   1  read request; accepted when req & ready on a rising clk
//  s0,s1      in   1  device select: {s0,s1} 00=fridge 01=aircon 10=washer 11=reserved
//  s2         in   1  unit: 0=unit1 1=unit2 (ignored for washer)
//  s3,s4      in   1  field: fridge 00 fgt 01 frt 10 fgc 11 frc; aircon 00 temp 01 cap 10 fan 11 timer
//  s5         in   1  fridge only: 1 selects ice bit (zero-extended), overrides s3/s4
//  fgt1,frt1,fgc1,frc1,fgt2,frt2,fgc2,frc2  in  W  fridge status
//  ice1,ice2  in   1  ice-maker status
//  actemp1,accap1,acfan1,actimer1,actemp2,accap2,acfan2,actimer2  in  W  aircon status
//  testing    in   W  washer status
//  ready      out  1  high when idle and able to accept req
//  tx         out  1  serial line, idle high
//  done       out  1  one-cycle pulse when the stop bit completes
//  err        out  1  sticky: last accepted request addressed reserved device 11
// BEHAVIOUR
//  Reset: ready=1, tx=1, done=0, err=0, FSM=IDLE, counters 0. Reset asserted mid-frame forces tx=1 at once (async).
//  Accept: in the cycle req&ready, register sel_val = mux(s0..s5); err <= (dev==11); reserved device sends 0.
//  Inputs are sampled only at accept; later status changes do not alter the frame in flight.
//  ready drops the cycle after accept; req while ready=0 is ignored (not queued).
//  FSM: IDLE -> START (tx=0) -> DATA (W bits, LSB first) -> [PARITY] -> STOP (tx=1) -> IDLE.
//  Each state holds CLKS_PER_BIT cycles. Baud counter counts 0..CLKS_PER_BIT-1, then wraps. Bit index counts 0..W-1.
//  First tx=0 appears the cycle after accept. done pulses in the last STOP cycle.
//  ready returns to 1 the following cycle, so a back-to-back req is accepted then: no idle bit between frames.
//  Frame length = (W+2[+1]) * CLKS_PER_BIT cycles.
//  Simultaneous done-cycle and req: req is not accepted (ready still 0); accept on next cycle.
//  err updates only on accept; cleared by reset or by a valid-device accept.
// CONFIGURATION
//  STATUS_PARITY_EN defined: PARITY state inserted after DATA, tx = ^sel_val (even parity); 8-bit frame.
//  Undefined: no PARITY state; 7-bit frame; the parity logic is not compiled.
// STRUCTURE
//  Shared package ld_pkg: device codes (DEV_FRIDGE, DEV_AC, DEV_WM, DEV_RSVD), field codes.
//  ld_pkg also holds the FSM state encoding (IDLE, START, DATA, PARITY, STOP) and the default W.
//  One sub-module: status_tx_shifter. It holds the baud counter, the bit counter and the shift register.
//  Its handshake: load/data in, busy/done out.
//  Selector mux lives in device_status_reader.
// TESTING
//  Reset, CLKS_PER_BIT=4: tx=1, ready=1, done=0, err=0; assert rst_n=0 mid-DATA -> tx=1 within same cycle.
//  fgt1=5'b10110, req with s=000000: frame 0,0,1,1,0,1,[1],1. Each level lasts 4 clks; done after the frame.
//  actimer2=5'h1F, s0=0 s1=1 s2=1 s3=1 s4=1: data bits all 1.
//  Also actimer2=5'h1F: with STATUS_PARITY_EN, parity=1; 28 cycles without it, 32 with it.
//  ice2=1, s0=0 s1=0 s2=1 s5=1: data=00001. Change ice2 to 0 mid-frame -> transmitted bits unchanged.
//  req held high continuously, two different addresses: second frame starts the cycle after done.
//  Held-high req: no extra idle bit; req during busy produces no third frame.
//  s0=1 s1=1 req -> err=1, data=00000. Next req to washer (testing=5'h0A) -> err=0, bits 0,1,0,1,0.

Source files
------------

// File: rtl/ld_pkg.sv
// Shared definitions for the appliance status read-back path: device/field
// selector codes, serial FSM state encoding and the default status width.
package ld_pkg;

  localparam int W_DEF = 5;

  typedef enum logic [1:0] {
    DEV_FRIDGE = 2'b00,
    DEV_AC     = 2'b01,
    DEV_WM     = 2'b10,
    DEV_RSVD   = 2'b11
  } dev_e;

  // Fridge fields selected by {s3,s4}
  localparam logic [1:0] FLD_FGT = 2'b00;
  localparam logic [1:0] FLD_FRT = 2'b01;
  localparam logic [1:0] FLD_FGC = 2'b10;
  localparam logic [1:0] FLD_FRC = 2'b11;

  // Aircon fields selected by {s3,s4}
  localparam logic [1:0] FLD_TEMP  = 2'b00;
  localparam logic [1:0] FLD_CAP   = 2'b01;
  localparam logic [1:0] FLD_FAN   = 2'b10;
  localparam logic [1:0] FLD_TIMER = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/device_status_reader_if.sv
// Request/selector/serial-line bundle between the read-back requester
// (master) and device_status_reader (slave).
interface device_status_reader_if;
  logic req;
  logic s0, s1, s2, s3, s4, s5;
  logic ready;
  logic tx;
  logic done;
  logic err;

  modport master (
    output req, s0, s1, s2, s3, s4, s5,
    input  ready, tx, done, err
  );

  modport slave (
    input  req, s0, s1, s2, s3, s4, s5,
    output ready, tx, done, err
  );
endinterface

// File: rtl/status_tx_shifter.sv
// UART-style frame generator: start bit, W data bits LSB first, optional even
// parity bit (STATUS_PARITY_EN), stop bit. Each bit lasts CLKS_PER_BIT clocks.
module status_tx_shifter
  import ld_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int W            = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  localparam int            BIT_W     = (W > 1) ? $clog2(W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  localparam logic [7:0]    BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  logic [2:0]       state;
  logic [7:0]       baud;
  logic [BIT_W-1:0] bit_idx;
  logic [W-1:0]     shreg;
  logic             baud_last;

`ifdef STATUS_PARITY_EN
  logic par_q;
`endif

  assign baud_last = (baud == BAUD_LAST);

  // NOTE: non-blocking (<=) for every flop so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef STATUS_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // Baud counter runs in every non-idle state and always wraps back to 0,
      // so it is already cleared when the next frame loads.
      if (state != ST_IDLE) baud <= baud_last ? 8'd0 : baud + 8'd1;

      case (state)
        ST_IDLE: begin
          if (load) begin
            state   <= ST_START;
            bit_idx <= '0;
            shreg   <= data;
`ifdef STATUS_PARITY_EN
            par_q   <= ^data;
`endif
          end
        end
        ST_START: if (baud_last) state <= ST_DATA;
        ST_DATA: begin
          if (baud_last) begin
            shreg <= shreg >> 1;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
`ifdef STATUS_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef STATUS_PARITY_EN
        ST_PARITY: if (baud_last) state <= ST_STOP;
`endif
        ST_STOP: if (baud_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_STOP) && baud_last;

  // Line level is decoded from registered state, so async reset idles it at once.
  // NOTE: default assignment first so no branch leaves tx unassigned (no latch).
  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
`ifdef STATUS_PARITY_EN
      ST_PARITY: tx = par_q;
`endif
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/device_status_reader.sv
// Selects one appliance status value via s0..s5, snapshots it on accept and
// sends it serially. Optional even parity bit: define STATUS_PARITY_EN.
module device_status_reader
  import ld_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int W            = W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  device_status_reader_if.slave        bus,
  input  logic [W-1:0]                 fgt1, frt1, fgc1, frc1,
  input  logic [W-1:0]                 fgt2, frt2, fgc2, frc2,
  input  logic                         ice1, ice2,
  input  logic [W-1:0]                 actemp1, accap1, acfan1, actimer1,
  input  logic [W-1:0]                 actemp2, accap2, acfan2, actimer2,
  input  logic [W-1:0]                 testing
);

  dev_e         dev;
  logic [1:0]   fld;
  logic [W-1:0] sel_val;
  logic         busy;
  logic         accept;
  logic         err_q;

  assign dev    = dev_e'({bus.s0, bus.s1});
  assign fld    = {bus.s3, bus.s4};
  assign accept = bus.req & ~busy;

  always_comb begin
    sel_val = '0;
    case (dev)
      DEV_FRIDGE: begin
        if (bus.s5) begin
          sel_val = W'(bus.s2 ? ice2 : ice1);
        end else begin
          case (fld)
            FLD_FGT: sel_val = bus.s2 ? fgt2 : fgt1;
            FLD_FRT: sel_val = bus.s2 ? frt2 : frt1;
            FLD_FGC: sel_val = bus.s2 ? fgc2 : fgc1;
            FLD_FRC: sel_val = bus.s2 ? frc2 : frc1;
          endcase
        end
      end
      DEV_AC: begin
        case (fld)
          FLD_TEMP:  sel_val = bus.s2 ? actemp2  : actemp1;
          FLD_CAP:   sel_val = bus.s2 ? accap2   : accap1;
          FLD_FAN:   sel_val = bus.s2 ? acfan2   : acfan1;
          FLD_TIMER: sel_val = bus.s2 ? actimer2 : actimer1;
        endcase
      end
      DEV_WM:  sel_val = testing;
      default: sel_val = '0;
    endcase
  end

  // err reflects only the most recent accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= (dev == DEV_RSVD);
  end

  status_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .W           (W)
  ) u_shifter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .data (sel_val),
    .busy (busy),
    .done (bus.done),
    .tx   (bus.tx)
  );

  assign bus.ready = ~busy;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_device_status_reader.sv
// Directed bench for device_status_reader: selector table plus multi-cycle
// sequences (snapshot, back-to-back, async reset mid-frame).
module tb_device_status_reader;

  localparam int C = 4;
  localparam int W = 5;
`ifdef STATUS_PARITY_EN
  localparam int NBITS = W + 3;
`else
  localparam int NBITS = W + 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] fgt1, frt1, fgc1, frc1, fgt2, frt2, fgc2, frc2;
  logic ice1, ice2;
  logic [W-1:0] actemp1, accap1, acfan1, actimer1;
  logic [W-1:0] actemp2, accap2, acfan2, actimer2;
  logic [W-1:0] testing;

  device_status_reader_if bus();

  device_status_reader #(.CLKS_PER_BIT(C), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fgt1(fgt1), .frt1(frt1), .fgc1(fgc1), .frc1(frc1),
    .fgt2(fgt2), .frt2(frt2), .fgc2(fgc2), .frc2(frc2),
    .ice1(ice1), .ice2(ice2),
    .actemp1(actemp1), .accap1(accap1), .acfan1(acfan1), .actimer1(actimer1),
    .actemp2(actemp2), .accap2(accap2), .acfan2(acfan2), .actimer2(actimer2),
    .testing(testing)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]   sel;   // {s0,s1,s2,s3,s4,s5}
    logic [W-1:0] data;
    logic         err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_sel(input logic [5:0] sel);
    {bus.s0, bus.s1, bus.s2, bus.s3, bus.s4, bus.s5} = sel;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (bus.ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.ready !== 1'b1) check({name, " ready timeout"}, 32'(bus.ready), 32'd1);
  endtask

  // Called right after the accepting posedge; returns on the negedge of the done cycle.
  task automatic capture_frame(input logic [W-1:0] exp_data, input logic exp_err,
                               input string name, input int poke);
    logic samples[$];
    logic [NBITS-1:0] exp_lvl;
    bit got_done = 0;
    exp_lvl[0] = 1'b0;
    for (int i = 0; i < W; i++) exp_lvl[1+i] = exp_data[i];
`ifdef STATUS_PARITY_EN
    exp_lvl[W+1] = ^exp_data;
`endif
    exp_lvl[NBITS-1] = 1'b1;
    for (int k = 0; k < 400 && !got_done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({name, " ready after accept"}, 32'(bus.ready), 32'd0);
        check({name, " err"}, 32'(bus.err), 32'(exp_err));
      end
      if (k == poke) ice2 = 1'b0;
      samples.push_back(bus.tx);
      if (bus.done === 1'b1) got_done = 1;
    end
    check({name, " frame length"}, 32'(samples.size()), 32'(NBITS * C));
    for (int b = 0; b < NBITS; b++) begin
      logic got_lvl;
      got_lvl = exp_lvl[b];
      for (int c = 0; c < C; c++) begin
        int idx;
        idx = b * C + c;
        if (got_lvl === exp_lvl[b]) begin
          if (idx >= samples.size()) got_lvl = 1'bx;
          else if (samples[idx] !== exp_lvl[b]) got_lvl = samples[idx];
        end
      end
      check($sformatf("%s level%0d", name, b), 32'(got_lvl), 32'(exp_lvl[b]));
    end
  endtask

  task automatic run_frame(input logic [5:0] sel, input logic [W-1:0] exp_data,
                           input logic exp_err, input string name, input int poke);
    wait_ready(name);
    set_sel(sel);
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    capture_frame(exp_data, exp_err, name, poke);
    @(negedge clk);
    check({name, " done one cycle"}, 32'(bus.done), 32'd0);
    check({name, " ready back"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    fgt1 = 5'b10110; frt1 = 5'b00011; fgc1 = 5'b01100; frc1 = 5'b11001;
    fgt2 = 5'b00111; frt2 = 5'b01110; fgc2 = 5'b10001; frc2 = 5'b11010;
    ice1 = 1'b0; ice2 = 1'b1;
    actemp1 = 5'b00101; accap1 = 5'b01001; acfan1 = 5'b10010; actimer1 = 5'b00100;
    actemp2 = 5'b11100; accap2 = 5'b10101; acfan2 = 5'b01011; actimer2 = 5'h1F;
    testing = 5'h0A;
    bus.req = 1'b0;
    set_sel(6'b000000);

    vecs[0]  = '{6'b000000, 5'b10110, 1'b0};  // fgt1
    vecs[1]  = '{6'b000010, 5'b00011, 1'b0};  // frt1
    vecs[2]  = '{6'b000110, 5'b11001, 1'b0};  // frc1
    vecs[3]  = '{6'b001100, 5'b10001, 1'b0};  // fgc2
    vecs[4]  = '{6'b001111, 5'b00001, 1'b0};  // ice2 overrides field
    vecs[5]  = '{6'b010010, 5'b01001, 1'b0};  // accap1
    vecs[6]  = '{6'b011100, 5'b01011, 1'b0};  // acfan2
    vecs[7]  = '{6'b011110, 5'h1F,    1'b0};  // actimer2
    vecs[8]  = '{6'b010001, 5'b00101, 1'b0};  // actemp1, s5 ignored
    vecs[9]  = '{6'b110000, 5'b00000, 1'b1};  // reserved
    vecs[10] = '{6'b100000, 5'h0A,    1'b0};  // washer clears err
    vecs[11] = '{6'b101011, 5'h0A,    1'b0};  // washer ignores s2/s3/s4/s5

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset tx", 32'(bus.tx), 32'd1);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);

    for (int i = 0; i < 12; i++)
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].err, $sformatf("vec%0d", i), -1);

    // Status changes after accept must not alter the frame in flight.
    run_frame(6'b001001, 5'b00001, 1'b0, "ice2 snapshot", 6);
    ice2 = 1'b1;

    // req held high across two frames; selector changes right after first accept.
    wait_ready("hold");
    set_sel(6'b000000);
    bus.req = 1'b1;
    @(posedge clk);
    #1 set_sel(6'b011110);
    capture_frame(5'b10110, 1'b0, "hold f1", -1);
    check("hold ready in done cycle", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("hold ready after done", 32'(bus.ready), 32'd1);
    check("hold tx idle gap", 32'(bus.tx), 32'd1);
    @(posedge clk);
    capture_frame(5'h1F, 1'b0, "hold f2", -1);
    bus.req = 1'b0;
    begin
      logic seen_busy = 1'b0;
      repeat (3 * C) begin
        @(negedge clk);
        if (bus.ready !== 1'b1 || bus.tx !== 1'b1) seen_busy = 1'b1;
      end
      check("no third frame", 32'(seen_busy), 32'd0);
    end

    // Async reset during the first data bit (fgt1[0]=0) idles the line immediately.
    wait_ready("rst");
    set_sel(6'b000000);
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (C + 1) @(negedge clk);
    check("pre-reset data bit", 32'(bus.tx), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid-frame reset tx", 32'(bus.tx), 32'd1);
    check("mid-frame reset ready", 32'(bus.ready), 32'd1);
    check("mid-frame reset done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(6'b000000, 5'b10110, 1'b0, "after reset", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
